// File: rtl/uart_step_counter_if.sv
// Bus bundle for uart_step_counter: step/clear/load controls in, count/tc out.
// wraps is present only when UART_STEP_COUNTER_WRAPS_EN is defined.
interface uart_step_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ena;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
`ifdef UART_STEP_COUNTER_WRAPS_EN
    logic [7:0]       wraps;

    modport master (output ena, clr, load, load_val, up, input count, tc, wraps);
    modport slave  (input ena, clr, load, load_val, up, output count, tc, wraps);
`else
    modport master (output ena, clr, load, load_val, up, input count, tc);
    modport slave  (input ena, clr, load, load_val, up, output count, tc);
`endif
endinterface

// File: rtl/uart_step_counter.sv
// Edge-stepped modulo up/down counter (one UART frame per cycle) with terminal-count pulse.
// Optional wrap-event counter enabled by defining UART_STEP_COUNTER_WRAPS_EN.
module uart_step_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 10,
    parameter int unsigned SATURATE = 0
) (
    input logic                  clk,
    input logic                  rst,
    uart_step_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ena_q;

    logic             w_step;
    logic             w_at_term;
    logic [WIDTH-1:0] w_count_step;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_step    = bus.ena & ~r_ena_q;
    assign w_at_term = bus.up ? (r_count == TERM_UP) : (r_count == '0);

    // Values above the last count state clamp to the terminal value
    assign w_load_clamped = ({1'b0, bus.load_val} >= MOD_EXT) ? TERM_UP : bus.load_val;

    // Next count for a step in the current direction
    always_comb begin
        w_count_step = r_count;
        if (w_at_term) begin
            if (SATURATE != 0) begin
                w_count_step = r_count;
            end else begin
                w_count_step = bus.up ? '0 : TERM_UP;
            end
        end else begin
            w_count_step = bus.up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
        end
    end

    // ena_q resets high so a level already asserted at reset release is not a step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ena_q <= 1'b1;
        end else begin
            r_ena_q <= bus.ena;
            if (bus.clr) begin
                r_count <= '0;
                r_tc    <= 1'b0;
            end else if (bus.load) begin
                r_count <= w_load_clamped;
                r_tc    <= 1'b0;
            end else if (w_step) begin
                r_count <= w_count_step;
                r_tc    <= w_at_term;
            end else begin
                r_tc    <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;

`ifdef UART_STEP_COUNTER_WRAPS_EN
    logic [7:0] r_wraps;

    // Counts tc assertions, saturating at 255
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_wraps <= '0;
        end else if (!bus.load && w_step && w_at_term && (r_wraps != 8'hFF)) begin
            r_wraps <= r_wraps + 8'd1;
        end
    end

    assign bus.wraps = r_wraps;
`endif
endmodule

// File: tb/tb_uart_step_counter.sv
// Self-checking bench for uart_step_counter: three configurations driven in lockstep,
// a directed vector table, hand-written corner sequences and randomized traffic vs a model.
module tb_uart_step_counter;
    logic       clk;
    logic       rst;
    logic       ena, clr, load, up;
    logic [3:0] lv;

    int n_checks;
    int n_fail;

    uart_step_counter_if #(.WIDTH(4)) if0 ();
    uart_step_counter_if #(.WIDTH(4)) if1 ();
    uart_step_counter_if #(.WIDTH(3)) if2 ();

    assign if0.ena = ena; assign if0.clr = clr; assign if0.load = load; assign if0.up = up;
    assign if1.ena = ena; assign if1.clr = clr; assign if1.load = load; assign if1.up = up;
    assign if2.ena = ena; assign if2.clr = clr; assign if2.load = load; assign if2.up = up;
    assign if0.load_val = lv;
    assign if1.load_val = lv;
    assign if2.load_val = 3'(lv);

    uart_step_counter u0 (.clk(clk), .rst(rst), .bus(if0));
    uart_step_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    uart_step_counter #(.WIDTH(3), .MODULO(8),  .SATURATE(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-instance state, rules applied with plain integer arithmetic
    int m_mod[3] = '{10, 10, 8};
    int m_sat[3] = '{0, 1, 0};
    int m_cnt[3];
    int m_tc[3];
    int m_enaq[3];
    int m_wraps[3];

    function automatic void model_update();
        for (int i = 0; i < 3; i++) begin
            int lvi;
            int term;
            bit rise;
            lvi  = (i == 2) ? (int'(lv) % 8) : int'(lv);
            rise = (ena == 1'b1) && (m_enaq[i] == 0);
            if (rst) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_enaq[i] = 1; m_wraps[i] = 0;
            end else begin
                m_enaq[i] = int'(ena);
                if (clr) begin
                    m_cnt[i] = 0; m_tc[i] = 0; m_wraps[i] = 0;
                end else if (load) begin
                    m_cnt[i] = (lvi >= m_mod[i]) ? m_mod[i] - 1 : lvi;
                    m_tc[i]  = 0;
                end else if (rise) begin
                    term     = up ? m_mod[i] - 1 : 0;
                    m_tc[i]  = (m_cnt[i] == term) ? 1 : 0;
                    if (!(m_tc[i] == 1 && m_sat[i] == 1))
                        m_cnt[i] = up ? (m_cnt[i] + 1) % m_mod[i]
                                      : (m_cnt[i] + m_mod[i] - 1) % m_mod[i];
                    if (m_tc[i] == 1 && m_wraps[i] < 255) m_wraps[i] = m_wraps[i] + 1;
                end else begin
                    m_tc[i] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int dc[3];
        int dt[3];
        model_update();
        @(posedge clk);
        #1;
        dc[0] = int'(if0.count); dc[1] = int'(if1.count); dc[2] = int'(if2.count);
        dt[0] = int'(if0.tc);    dt[1] = int'(if1.tc);    dt[2] = int'(if2.tc);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_count", i), dc[i], m_cnt[i]);
            chk($sformatf("u%0d_tc", i), dt[i], m_tc[i]);
        end
`ifdef UART_STEP_COUNTER_WRAPS_EN
        chk("u0_wraps", int'(if0.wraps), m_wraps[0]);
        chk("u1_wraps", int'(if1.wraps), m_wraps[1]);
        chk("u2_wraps", int'(if2.wraps), m_wraps[2]);
`endif
    endtask

    task automatic pulse();
        ena = 1'b1; tick();
        ena = 1'b0; tick();
    endtask

    typedef struct {
        logic       ena, clr, load;
        logic [3:0] lv;
        logic       up;
        int         exp_cnt;
        int         exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic c, input logic l,
                                input logic [3:0] v, input logic u, input int ec, input int et);
        vec_t r;
        r.ena = e; r.clr = c; r.load = l; r.lv = v; r.up = u; r.exp_cnt = ec; r.exp_tc = et;
        vecs.push_back(r);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; ena = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1; lv = '0;

        // Directed table for the default configuration (u0)
        add(0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            add(1, 0, 0, 0, 1, k % 10, (k == 10) ? 1 : 0);
            add(0, 0, 0, 0, 1, k % 10, 0);
        end
        add(1, 0, 0, 0, 0, 9, 1);
        add(0, 0, 0, 0, 0, 9, 0);
        add(1, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 19; k++) add(1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 15, 1, 9, 0);
        add(1, 0, 0, 0, 1, 9, 0);
        add(0, 0, 0, 0, 1, 9, 0);
        add(0, 0, 1, 5, 1, 5, 0);
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);

        tick(); tick();
        chk("reset_count", int'(if0.count), 0);
        chk("reset_tc", int'(if0.tc), 0);
        rst = 1'b0;

        foreach (vecs[n]) begin
            ena = vecs[n].ena; clr = vecs[n].clr; load = vecs[n].load;
            lv = vecs[n].lv; up = vecs[n].up;
            tick();
            chk($sformatf("vec%0d_count", n), int'(if0.count), vecs[n].exp_cnt);
            chk($sformatf("vec%0d_tc", n), int'(if0.tc), vecs[n].exp_tc);
        end
        clr = 1'b0; load = 1'b0; ena = 1'b0;

        // Down step from 0: wrap (u0) versus saturate (u1)
        clr = 1'b1; tick(); clr = 1'b0;
        up = 1'b0; ena = 1'b1; tick();
        chk("down_wrap_count", int'(if0.count), 9);
        chk("down_wrap_tc", int'(if0.tc), 1);
        chk("down_sat_count", int'(if1.count), 0);
        chk("down_sat_tc", int'(if1.tc), 1);
        ena = 1'b0; up = 1'b1; tick();

        // ena held high through reset release produces no step
        ena = 1'b1; rst = 1'b1; tick(); tick();
        rst = 1'b0; tick(); tick(); tick();
        chk("ena_thru_rst_count", int'(if0.count), 0);
        ena = 1'b0; tick();

        // Reset mid-stream at count 7 with a pending rising edge
        for (int k = 0; k < 7; k++) pulse();
        chk("pre_rst_count", int'(if0.count), 7);
        ena = 1'b1; rst = 1'b1; tick();
        chk("mid_rst_count", int'(if0.count), 0);
        chk("mid_rst_tc", int'(if0.tc), 0);
        rst = 1'b0; ena = 1'b0; tick();

        // Long up run: clean wrap on the 3-bit counter, then wrap counter saturation
        clr = 1'b1; tick(); clr = 1'b0; up = 1'b1;
        for (int k = 0; k < 300; k++) pulse();
        chk("w3_300_count", int'(if2.count), 4);
        for (int k = 0; k < 1800; k++) pulse();
`ifdef UART_STEP_COUNTER_WRAPS_EN
        chk("w3_wraps_sat", int'(if2.wraps), 255);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rst  = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 29) == 0);
            load = ($urandom_range(0, 14) == 0);
            lv   = 4'($urandom_range(0, 15));
            ena  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) up = ~up;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_step_counter.md
UART_STEP_COUNTER -- requirements
Module: uart_step_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MODULO, default 10, count states per cycle (one UART frame: start + 8 data + stop); legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at terminal, 1 = hold at terminal.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ena  input  1  step request, level signal; one step per 0->1 transition.
REQ-007 clr  input  1  synchronous clear of count.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal-count pulse, registered.

Function
REQ-013 The block shall register ena into ena_q every cycle; step = ena & ~ena_q.
REQ-014 Per-edge priority shall be rst > clr > load > step > hold.
REQ-015 A step shall update count at the same edge at which it is detected; the new value is visible in the next cycle.
REQ-016 Up step: count < MODULO-1 -> count+1; count == MODULO-1 -> 0 (SATURATE=0) or hold (SATURATE=1).
REQ-017 Down step: count > 0 -> count-1; count == 0 -> MODULO-1 (SATURATE=0) or hold (SATURATE=1).
REQ-018 tc shall be 1 for exactly one cycle after any step taken while count is at the terminal value for the current direction; otherwise 0.
REQ-019 Load shall set count to load_val, clamped to MODULO-1 when load_val >= MODULO; tc = 0.
REQ-020 Clr shall set count to 0 and tc to 0.
REQ-021 A rising edge of ena coinciding with clr or load shall be dropped, not deferred.
REQ-022 ena_q shall update on every non-reset edge, including clr and load edges.
REQ-023 Holding ena high shall produce no further steps until ena returns low for at least one cycle.
REQ-024 A change of up takes effect at the next step; count is unaffected.
REQ-025 Arithmetic shall be WIDTH bits; count shall never leave 0..MODULO-1.

Reset
REQ-026 On rst: count = 0, tc = 0, ena_q = 1; wraps = 0 when present.
REQ-027 Setting ena_q to 1 on reset shall suppress a step if ena is already high when rst deasserts.
REQ-028 Reset mid-operation shall discard any pending step and the in-progress count.

Configuration
REQ-029 Macro UART_STEP_COUNTER_WRAPS_EN shall control the wrap-event counter.
REQ-030 With the macro defined, the block shall add output port wraps [7:0].
REQ-031 wraps shall increment on each tc assertion and saturate at 255.
REQ-032 wraps shall be cleared by rst and by clr.
REQ-033 Without the macro, the wraps port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-034 Defaults, up = 1, 10 ena pulses from count 0 -> count sequence 1..9, then 0; single tc pulse after 10th step; wraps = 1 when macro defined.
REQ-035 up = 0 from count 0, one ena pulse -> count = 9, tc pulse; SATURATE=1, same stimulus -> count = 0, tc pulse.
REQ-036 ena held high for 20 cycles -> exactly one step; ena high through rst release -> no step.
REQ-037 load_val = 15 with MODULO = 10 -> count = 9; load and ena rising edge in same cycle -> count = load value, no step.
REQ-038 count = 5, clr coincident with ena rising edge -> count = 0, tc = 0; rst at count = 7 mid-stream -> count = 0, tc = 0 next cycle.
REQ-039 WIDTH = 3, MODULO = 8, 300 up steps -> count wraps cleanly; wraps saturates at 255 when macro defined.
